// File: rtl/tank_bullet.sv
// tank_bullet: single-bullet projectile engine for one tank.
// Launches from the cell ahead of the tank, steps on frame ticks, dies on map exit or hit.
module tank_bullet #(
  parameter int X_MAX          = 39,
  parameter int Y_MAX          = 29,
  parameter int STEP_TICKS     = 2,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       fire,
  input  logic [5:0] tank_x,
  input  logic [5:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic       hit,
  output logic       bullet_valid,
  output logic [5:0] bullet_x,
  output logic [5:0] bullet_y,
  output logic [1:0] bullet_dir,
  output logic       fire_ready
);

  // state    | meaning
  // IDLE     | no bullet; fire accepted, held in pending until the next tick
  // FLY      | bullet alive, one cell per STEP_TICKS ticks
  // COOLDOWN | bullet dead, reloading for COOLDOWN_TICKS ticks
  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, COOLDOWN = 2'd2} state_t;

  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic [7:0] cd_cnt_q, cd_cnt_d;
  logic       valid_q, valid_d;
  logic [5:0] x_q, x_d, y_q, y_d;
  logic [1:0] dir_q, dir_d;

  logic       launch_req, launch_ok, move_due, exit_map, cd_done;
  logic [5:0] launch_x, launch_y, move_x, move_y;

  // True when one more step in d would leave the map; checked before any add/subtract.
  function automatic logic at_edge(input logic [5:0] x, input logic [5:0] y, input logic [1:0] d);
    case (d)
      DIR_UP:   at_edge = (y >= 6'(Y_MAX));
      DIR_DOWN: at_edge = (y == 6'd0);
      DIR_LEFT: at_edge = (x == 6'd0);
      default:  at_edge = (x >= 6'(X_MAX));
    endcase
  endfunction

  function automatic logic [11:0] step_cell(input logic [5:0] x, input logic [5:0] y,
                                            input logic [1:0] d);
    case (d)
      DIR_UP:   step_cell = {x, y + 6'd1};
      DIR_DOWN: step_cell = {x, y - 6'd1};
      DIR_LEFT: step_cell = {x - 6'd1, y};
      default:  step_cell = {x + 6'd1, y};
    endcase
  endfunction

  assign {launch_x, launch_y} = step_cell(tank_x, tank_y, tank_dir);
  assign {move_x, move_y}     = step_cell(x_q, y_q, dir_q);

  assign launch_req = (state_q == IDLE) && tick && (fire || pending_q);
  assign launch_ok  = launch_req && !at_edge(tank_x, tank_y, tank_dir);
  assign move_due   = (state_q == FLY) && tick && !hit && (step_cnt_q == 4'(STEP_TICKS - 1));
  assign exit_map   = move_due && at_edge(x_q, y_q, dir_q);
  assign cd_done    = (state_q == COOLDOWN) &&
                      ((COOLDOWN_TICKS == 0) ||
                       (tick && (({1'b0, cd_cnt_q} + 9'd1) >= 9'(COOLDOWN_TICKS))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      step_cnt_q <= '0;
      cd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      step_cnt_q <= step_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (launch_ok) state_d = FLY;
      FLY:      if (hit || exit_map) state_d = COOLDOWN;
      COOLDOWN: if (cd_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d  = pending_q;
    step_cnt_d = step_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    unique case (state_q)
      IDLE: begin
        if (launch_req) pending_d = 1'b0;
        else if (fire)  pending_d = 1'b1;
        if (launch_ok) begin
          x_d        = launch_x;
          y_d        = launch_y;
          dir_d      = tank_dir;
          valid_d    = 1'b1;
          step_cnt_d = '0;
        end
      end
      FLY: begin
        // hit beats a same-cycle move: the bullet dies where it was drawn.
        if (hit) begin
          valid_d  = 1'b0;
          cd_cnt_d = '0;
        end else if (move_due) begin
          step_cnt_d = '0;
          if (exit_map) begin
            valid_d  = 1'b0;
            cd_cnt_d = '0;
          end else begin
            x_d = move_x;
            y_d = move_y;
          end
        end else if (tick) begin
          step_cnt_d = step_cnt_q + 4'd1;
        end
      end
      COOLDOWN: if (tick) cd_cnt_d = cd_cnt_q + 8'd1;
      default: ;
    endcase
  end

  always_comb begin
    fire_ready   = (state_q == IDLE);
    bullet_valid = valid_q;
    bullet_x     = x_q;
    bullet_y     = y_q;
    bullet_dir   = dir_q;
  end

endmodule

// File: tb/tb_tank_bullet.sv
// Bench for tank_bullet: two instances (default timing, and STEP_TICKS=1/COOLDOWN_TICKS=0)
// checked every cycle against a tick-counting model, plus hand-computed directed checks.
module tb_tank_bullet;
  localparam int XM = 39;
  localparam int YM = 29;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, fire = 1'b0, hit = 1'b0;
  logic [5:0] tank_x = '0, tank_y = '0;
  logic [1:0] tank_dir = '0;

  logic [1:0]      d_valid, d_ready;
  logic [1:0][5:0] d_x, d_y;
  logic [1:0][1:0] d_dir;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  tank_bullet #(.X_MAX(XM), .Y_MAX(YM), .STEP_TICKS(2), .COOLDOWN_TICKS(8)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire), .tank_x(tank_x), .tank_y(tank_y),
    .tank_dir(tank_dir), .hit(hit), .bullet_valid(d_valid[0]), .bullet_x(d_x[0]),
    .bullet_y(d_y[0]), .bullet_dir(d_dir[0]), .fire_ready(d_ready[0]));

  tank_bullet #(.X_MAX(XM), .Y_MAX(YM), .STEP_TICKS(1), .COOLDOWN_TICKS(0)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire), .tank_x(tank_x), .tank_y(tank_y),
    .tank_dir(tank_dir), .hit(hit), .bullet_valid(d_valid[1]), .bullet_x(d_x[1]),
    .bullet_y(d_y[1]), .bullet_dir(d_dir[1]), .fire_ready(d_ready[1]));

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 flying, 2 reloading; counts ticks rather than tracking counters.
  int p_step[2] = '{2, 1};
  int p_cd[2]   = '{8, 0};
  int m_mode[2], m_tl[2], m_tc[2], m_x[2], m_y[2], m_dir[2];
  bit m_pend[2], m_v[2];

  task automatic ahead(input int x, input int y, input int d, output int nx, output int ny);
    nx = x; ny = y;
    case (d)
      0: ny = y + 1;
      1: ny = y - 1;
      2: nx = x - 1;
      default: nx = x + 1;
    endcase
  endtask

  function automatic bit on_map(input int x, input int y);
    return x >= 0 && x <= XM && y >= 0 && y <= YM;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nx, ny;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_tl[i] = 0; m_tc[i] = 0; m_pend[i] = 0;
        m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_mode[i])
          0: begin
            if (tick && (fire || m_pend[i])) begin
              m_pend[i] = 0;
              ahead(int'(tank_x), int'(tank_y), int'(tank_dir), nx, ny);
              if (on_map(nx, ny)) begin
                m_x[i] = nx; m_y[i] = ny; m_dir[i] = int'(tank_dir);
                m_v[i] = 1; m_tl[i] = 0; m_mode[i] = 1;
              end
            end else if (fire) m_pend[i] = 1;
          end
          1: begin
            if (hit) begin
              m_v[i] = 0; m_tc[i] = 0; m_mode[i] = 2;
            end else if (tick) begin
              m_tl[i]++;
              if (m_tl[i] % p_step[i] == 0) begin
                ahead(m_x[i], m_y[i], m_dir[i], nx, ny);
                if (on_map(nx, ny)) begin
                  m_x[i] = nx; m_y[i] = ny;
                end else begin
                  m_v[i] = 0; m_tc[i] = 0; m_mode[i] = 2;
                end
              end
            end
          end
          default: begin
            if (p_cd[i] == 0) m_mode[i] = 0;
            else if (tick) begin
              m_tc[i]++;
              if (m_tc[i] == p_cd[i]) m_mode[i] = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model%0d.valid", i), int'(d_valid[i]), int'(m_v[i]));
        check($sformatf("model%0d.ready", i), int'(d_ready[i]), (m_mode[i] == 0) ? 1 : 0);
        check($sformatf("model%0d.x", i), int'(d_x[i]), m_x[i]);
        check($sformatf("model%0d.y", i), int'(d_y[i]), m_y[i]);
        check($sformatf("model%0d.dir", i), int'(d_dir[i]), m_dir[i]);
      end
    end
  end

  task automatic step(input logic t, input logic f, input logic h);
    tick = t; fire = f; hit = h;
    @(posedge clk);
    #1;
    tick = 1'b0; fire = 1'b0; hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_x = 6'(x); tank_y = 6'(y); tank_dir = 2'(d);
  endtask

  initial begin
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset.valid", int'(d_valid[0]), 0);
    check("reset.ready", int'(d_ready[0]), 1);
    check("reset.x", int'(d_x[0]), 0);

    // launch from (10,10) RIGHT, then two-tick moves
    set_tank(10, 10, 3);
    step(1'b1, 1'b1, 1'b0);
    check("launch.valid", int'(d_valid[0]), 1);
    check("launch.x", int'(d_x[0]), 11);
    check("launch.y", int'(d_y[0]), 10);
    check("launch.dir", int'(d_dir[0]), 3);
    check("launch.ready", int'(d_ready[0]), 0);
    set_tank(30, 20, 0);
    ticks(2);
    check("move1.x", int'(d_x[0]), 12);
    ticks(2);
    check("move2.x", int'(d_x[0]), 13);

    // hit on a move tick: dies in place; fire during reload is dropped
    ticks(1);
    step(1'b1, 1'b0, 1'b1);
    check("hit.valid", int'(d_valid[0]), 0);
    check("hit.x", int'(d_x[0]), 13);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    ticks(6);
    check("cool7.ready", int'(d_ready[0]), 0);
    ticks(1);
    check("cool8.ready", int'(d_ready[0]), 1);
    ticks(3);
    check("dropped_fire.valid", int'(d_valid[0]), 0);

    // launch cell off the map: no launch, pending cleared
    set_tank(39, 5, 3);
    step(1'b1, 1'b1, 1'b0);
    check("oob_r.valid", int'(d_valid[0]), 0);
    check("oob_r.ready", int'(d_ready[0]), 1);
    ticks(1);
    check("oob_r.pending", int'(d_valid[0]), 0);
    set_tank(0, 5, 2);
    step(1'b1, 1'b1, 1'b0);
    check("oob_l.valid", int'(d_valid[0]), 0);
    ticks(1);
    check("oob_l.pending", int'(d_valid[0]), 0);

    // left-edge exit must not wrap x
    set_tank(2, 3, 2);
    step(1'b1, 1'b1, 1'b0);
    check("edge.launch_x", int'(d_x[0]), 1);
    ticks(2);
    check("edge.x0", int'(d_x[0]), 0);
    check("edge.alive", int'(d_valid[0]), 1);
    ticks(2);
    check("edge.valid", int'(d_valid[0]), 0);
    check("edge.x_nowrap", int'(d_x[0]), 0);
    check("edge.ready", int'(d_ready[0]), 0);
    ticks(7);
    check("edge.cool7", int'(d_ready[0]), 0);
    ticks(1);
    check("edge.cool8", int'(d_ready[0]), 1);

    // fire alone, tank moves, launch on the later tick from the new cell
    set_tank(20, 20, 0);
    step(1'b0, 1'b1, 1'b0);
    check("pend.no_launch", int'(d_valid[0]), 0);
    step(1'b0, 1'b0, 1'b0);
    set_tank(21, 20, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pend.valid", int'(d_valid[0]), 1);
    check("pend.x", int'(d_x[0]), 21);
    check("pend.y", int'(d_y[0]), 19);
    check("pend.dir", int'(d_dir[0]), 1);

    // async reset between edges mid-flight
    ticks(1);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", int'(d_valid[0]), 0);
    check("arst.x", int'(d_x[0]), 0);
    check("arst.y", int'(d_y[0]), 0);
    check("arst.dir", int'(d_dir[0]), 0);
    check("arst.ready", int'(d_ready[0]), 1);
    @(negedge clk);
    rst = 1'b0;

    // zero-cooldown instance returns to idle the cycle after death
    set_tank(38, 7, 3);
    step(1'b1, 1'b1, 1'b0);
    check("cd0.launch", int'(d_valid[1]), 1);
    check("cd0.x", int'(d_x[1]), 39);
    ticks(1);
    check("cd0.dead", int'(d_valid[1]), 0);
    check("cd0.x_held", int'(d_x[1]), 39);
    check("cd0.ready_low", int'(d_ready[1]), 0);
    step(1'b0, 1'b0, 1'b0);
    check("cd0.ready_back", int'(d_ready[1]), 1);
    ticks(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_bullet.md
# tank_bullet

Per-tank projectile engine, one instance per tank, sitting directly downstream of the tank movement block. It consumes the tank's grid position and facing direction plus a fire request. It launches one bullet at a time from the cell in front of the tank and advances it on frame ticks. The bullet is removed on a map-edge exit or a game-reported hit, followed by a reload cooldown. Outputs feed the game logic (collision) and the VGA renderer.

## Interface
- X_MAX, 39: largest legal x cell (map x range 0..X_MAX)
- Y_MAX, 29: largest legal y cell (map y range 0..Y_MAX)
- STEP_TICKS, 2: ticks per one-cell bullet move, legal range 1..15
- COOLDOWN_TICKS, 8: ticks spent in COOLDOWN after a bullet dies, legal range 0..255

- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  frame tick, one-cycle pulse; same strobe the tank block uses as valid_take_direction
- fire  in  1  fire request pulse, any cycle
- tank_x  in  6  tank x cell
- tank_y  in  6  tank y cell
- tank_dir  in  2  tank facing: 0 UP (y+1), 1 DOWN (y-1), 2 LEFT (x-1), 3 RIGHT (x+1)
- hit  in  1  game logic reports that the live bullet collided; kill it
- bullet_valid  out  1  bullet alive and drawable
- bullet_x  out  6  bullet x cell
- bullet_y  out  6  bullet y cell
- bullet_dir  out  2  bullet travel direction, same encoding as tank_dir
- fire_ready  out  1  high in IDLE; a fire is accepted

## Operation
- States: IDLE, FLY, COOLDOWN. Reset: IDLE, pending=0, step_cnt=0, cd_cnt=0, bullet_valid=0, bullet_x=0, bullet_y=0, bullet_dir=0. fire_ready=1, decoded from IDLE.
- pending latch: set by fire while IDLE. Cleared on launch, on suppressed launch, and on reset. fire in FLY or COOLDOWN is dropped and not latched.
- IDLE, on tick with (fire | pending): compute the launch cell = tank cell stepped once in tank_dir.
  - Cell in bounds: load bullet_x/y and bullet_dir=tank_dir, set bullet_valid=1, step_cnt=0, go to FLY.
  - Cell out of bounds: no launch, clear pending, stay IDLE.
- FLY, on tick: if step_cnt==STEP_TICKS-1, move one cell in bullet_dir and set step_cnt=0; otherwise step_cnt+1.
- Move off the map (x==0 LEFT, x==X_MAX RIGHT, y==0 DOWN, y==Y_MAX UP): bullet_valid=0, position held, cd_cnt=0, go to COOLDOWN.
- Bounds are checked before the add/subtract. The 6-bit position never wraps (0 minus 1 must not become 63).
- FLY, hit=1 (any cycle, tick or not): bullet_valid=0, go to COOLDOWN. hit wins over a same-cycle move, and position is not updated. hit outside FLY is ignored.
- COOLDOWN, on tick: cd_cnt+1. When cd_cnt reaches COOLDOWN_TICKS, go to IDLE. With COOLDOWN_TICKS=0, go to IDLE on the cycle after entry without needing a tick.
- bullet_x/y/dir hold their last values when bullet_valid=0. Consumers must qualify them with bullet_valid.
- Tank inputs are sampled only at launch. Tank motion after launch does not affect the bullet.

## Timing
- All outputs are registered. Async rst forces the reset values immediately, including mid-flight (the bullet vanishes and pending is lost).
- Launch latency: the edge where tick meets (fire|pending) in IDLE updates bullet_valid/x/y on that edge. fire and tick in the same cycle launch on that edge.
- The launch tick does not count toward STEP_TICKS. With STEP_TICKS=2, the first move happens on the 2nd tick after launch.
- hit: bullet_valid falls on the edge where hit=1 is sampled. fire_ready rises COOLDOWN_TICKS ticks later.
- A fire on a non-tick cycle in IDLE launches on the next tick.

## Test plan
- Reset, tank (10,10) dir RIGHT, fire+tick → bullet_valid=1, (11,10), dir 3. Two ticks later → (12,10). Two more → (13,10).
- Tank (39,5) RIGHT, fire+tick → no launch, fire_ready stays 1, pending cleared. Tank (0,5) LEFT: same result.
- Bullet at (1,3) LEFT, STEP_TICKS=2 → (0,3) after 2 ticks. 2 more ticks → bullet_valid=0, x stays 0 (not 63), COOLDOWN. After 8 ticks → fire_ready=1.
- Bullet flying, hit on the same cycle as a move tick → bullet_valid=0, position unchanged. fire during COOLDOWN dropped: no launch after return to IDLE without a new fire.
- fire pulse alone at cycle 5, tick at cycle 9 → launch at cycle 9. Tank moved at cycle 7 → launch uses the cycle-9 tank cell.
- rst asserted mid-FLY between clock edges → outputs go to reset values before the next edge. COOLDOWN_TICKS=0 case: IDLE one cycle after bullet death.
